// File: rtl/traffic_pkg.sv
// Shared types, lamp codes and phase durations for the intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5,
        PED_WALK    = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    function automatic logic [7:0] dur_of(
        input state_t     s,
        input logic [7:0] green,
        input logic [7:0] yellow,
        input logic [7:0] allred,
        input logic [7:0] walk
    );
        logic [7:0] d;
        d = allred;
        unique case (s)
            MAIN_GREEN, SIDE_GREEN:   d = green;
            MAIN_YELLOW, SIDE_YELLOW: d = yellow;
            PED_WALK:                 d = walk;
            default:                  d = allred;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts qualified ticks since phase entry; done fires on the tick that
// completes the phase.
module dwell_timer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic       tick_i,
    input  logic [7:0] limit_i,
    output logic       done_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;
    logic       step;

    assign step   = tick_i & en_i;
    assign done_o = step & (count_q == (limit_i - 8'd1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (step) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer with a latched pedestrian walk phase,
// advanced by an external half-second tick.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_TICKS  = 20,
    parameter int unsigned YELLOW_TICKS = 6,
    parameter int unsigned ALLRED_TICKS = 2,
    parameter int unsigned WALK_TICKS   = 10
) (
    input  logic       CLOCK50_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       enable_i,
    input  logic       ped_req_i,
    output logic [2:0] main_light_o,
    output logic [2:0] side_light_o,
    output logic       ped_walk_o,
    output logic       ped_ack_o,
    output logic [2:0] state_o
);

    if (GREEN_TICKS < 1 || GREEN_TICKS > 255 ||
        YELLOW_TICKS < 1 || YELLOW_TICKS > 255 ||
        ALLRED_TICKS < 1 || ALLRED_TICKS > 255 ||
        WALK_TICKS < 1 || WALK_TICKS > 255) begin : g_bad_dur
        $error("traffic_light_ctrl: phase durations must be 1..255");
    end

    localparam logic [7:0] G8 = GREEN_TICKS[7:0];
    localparam logic [7:0] Y8 = YELLOW_TICKS[7:0];
    localparam logic [7:0] A8 = ALLRED_TICKS[7:0];
    localparam logic [7:0] W8 = WALK_TICKS[7:0];

    state_t     state_q;
    state_t     state_d;
    logic       pending_q;
    logic       pending_d;
    logic       ack_q;
    logic       walk_go;
    logic       done;
    logic [7:0] limit;

    assign limit = dur_of(state_q, G8, Y8, A8, W8);

    dwell_timer u_dwell (
        .clk_i   (CLOCK50_i),
        .rst_i   (rst_i),
        .clear_i (done),
        .en_i    (enable_i),
        .tick_i  (tick_i),
        .limit_i (limit),
        .done_o  (done)
    );

    always_comb begin
        state_d = state_q;
        walk_go = 1'b0;
        if (done) begin
            unique case (state_q)
                MAIN_GREEN:  state_d = MAIN_YELLOW;
                MAIN_YELLOW: state_d = ALL_RED_A;
                ALL_RED_A:   state_d = SIDE_GREEN;
                SIDE_GREEN:  state_d = SIDE_YELLOW;
                SIDE_YELLOW: state_d = ALL_RED_B;
                ALL_RED_B: begin
                    // A press in the exit cycle itself still earns this walk.
                    if (pending_q || ped_req_i) begin
                        state_d = PED_WALK;
                        walk_go = 1'b1;
                    end else begin
                        state_d = MAIN_GREEN;
                    end
                end
                default:     state_d = MAIN_GREEN;
            endcase
        end
        pending_d = walk_go ? 1'b0 : (pending_q | ped_req_i);
    end

    always_ff @(posedge CLOCK50_i) begin
        if (rst_i) begin
            state_q   <= ALL_RED_B;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ack_q     <= walk_go;
        end
    end

    always_comb begin
        main_light_o = LAMP_R;
        side_light_o = LAMP_R;
        unique case (state_q)
            MAIN_GREEN:  main_light_o = LAMP_G;
            MAIN_YELLOW: main_light_o = LAMP_Y;
            SIDE_GREEN:  side_light_o = LAMP_G;
            SIDE_YELLOW: side_light_o = LAMP_Y;
            default: begin
                main_light_o = LAMP_R;
                side_light_o = LAMP_R;
            end
        endcase
    end

    assign ped_walk_o = (state_q == PED_WALK);
    assign ped_ack_o  = ack_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: scripted scenarios with literal checks plus a
// randomized run compared every cycle against a phase-level model.
module tb_traffic_light_ctrl;
    import traffic_pkg::*;

    localparam int G = 3;
    localparam int Y = 2;
    localparam int A = 1;
    localparam int W = 2;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       tick_i = 1'b0;
    logic       enable_i = 1'b1;
    logic       ped_req_i = 1'b0;
    logic [2:0] main_light_o;
    logic [2:0] side_light_o;
    logic       ped_walk_o;
    logic       ped_ack_o;
    logic [2:0] state_o;

    int errors = 0;
    int checks = 0;
    int ack_cnt = 0;
    int tcnt = 0;
    bit rand_mode = 0;

    traffic_light_ctrl #(
        .GREEN_TICKS  (G),
        .YELLOW_TICKS (Y),
        .ALLRED_TICKS (A),
        .WALK_TICKS   (W)
    ) dut (
        .CLOCK50_i    (clk),
        .rst_i        (rst_i),
        .tick_i       (tick_i),
        .enable_i     (enable_i),
        .ped_req_i    (ped_req_i),
        .main_light_o (main_light_o),
        .side_light_o (side_light_o),
        .ped_walk_o   (ped_walk_o),
        .ped_ack_o    (ped_ack_o),
        .state_o      (state_o)
    );

    always #10 clk = ~clk;

    // Phase-level reference: which phase, how many ticks spent in it, and
    // whether a walk has been requested.
    state_t m_ph;
    int     m_ticks;
    bit     m_pend;
    bit     m_ack;
    bit     m_valid = 0;

    function automatic int dur_tb(state_t s);
        case (s)
            MAIN_GREEN, SIDE_GREEN:   return G;
            MAIN_YELLOW, SIDE_YELLOW: return Y;
            PED_WALK:                 return W;
            default:                  return A;
        endcase
    endfunction

    function automatic logic [2:0] lamp_main(state_t s);
        if (s == MAIN_GREEN)  return 3'b001;
        if (s == MAIN_YELLOW) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] lamp_side(state_t s);
        if (s == SIDE_GREEN)  return 3'b001;
        if (s == SIDE_YELLOW) return 3'b010;
        return 3'b100;
    endfunction

    always @(posedge clk) begin
        bit go_walk;
        go_walk = 0;
        if (rst_i) begin
            m_ph    = ALL_RED_B;
            m_ticks = 0;
            m_pend  = 0;
            m_ack   = 0;
            m_valid = 1;
        end else if (m_valid) begin
            m_ack = 0;
            if (tick_i && enable_i) begin
                m_ticks++;
                if (m_ticks == dur_tb(m_ph)) begin
                    m_ticks = 0;
                    case (m_ph)
                        MAIN_GREEN:  m_ph = MAIN_YELLOW;
                        MAIN_YELLOW: m_ph = ALL_RED_A;
                        ALL_RED_A:   m_ph = SIDE_GREEN;
                        SIDE_GREEN:  m_ph = SIDE_YELLOW;
                        SIDE_YELLOW: m_ph = ALL_RED_B;
                        ALL_RED_B: begin
                            go_walk = m_pend || ped_req_i;
                            m_ph = go_walk ? PED_WALK : MAIN_GREEN;
                        end
                        default:     m_ph = MAIN_GREEN;
                    endcase
                end
            end
            if (go_walk) begin
                m_pend = 0;
                m_ack  = 1;
            end else if (ped_req_i) begin
                m_pend = 1;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ped_ack_o) ack_cnt++;
        if (m_valid) begin
            chk("model.main", main_light_o, lamp_main(m_ph));
            chk("model.side", side_light_o, lamp_side(m_ph));
            chk("model.walk", ped_walk_o, (m_ph == PED_WALK));
            chk("model.ack", ped_ack_o, m_ack);
            chk("model.state", state_o, m_ph);
            checks++;
            a_nodual: assert (!(main_light_o[0] && side_light_o[0])) else begin
                errors++;
                $display("FAIL dual_green: main=%b side=%b", main_light_o, side_light_o);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        tcnt++;
        if (rand_mode) tick_i = ($urandom_range(0, 3) == 0);
        else           tick_i = (tcnt % 4 == 0);
    endtask

    task automatic next_tick();
        int n = 0;
        while (!tick_i && n < 20) begin
            cyc();
            n++;
        end
        cyc();
    endtask

    task automatic wait_state(input state_t s);
        int n = 0;
        while (state_t'(state_o) != s && n < 200) begin
            cyc();
            n++;
        end
        checks++;
        if (state_t'(state_o) != s) begin
            errors++;
            $display("FAIL wait_state: got %0d expected %0d (timeout)", state_o, s);
        end
    endtask

    initial begin
        state_t seq[6];
        int     dur[6];
        int     acks0;
        seq = '{MAIN_GREEN, MAIN_YELLOW, ALL_RED_A,
                SIDE_GREEN, SIDE_YELLOW, ALL_RED_B};
        dur = '{3, 2, 1, 3, 2, 1};

        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
        chk("rst.main", main_light_o, 3'b100);
        chk("rst.side", side_light_o, 3'b100);
        chk("rst.walk", ped_walk_o, 0);
        chk("rst.ack", ped_ack_o, 0);
        chk("rst.state", state_o, ALL_RED_B);

        next_tick();
        chk("first.main", main_light_o, 3'b001);
        chk("first.side", side_light_o, 3'b100);

        acks0 = ack_cnt;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < dur[i]; k++) begin
                chk("cycle.state", state_o, seq[i]);
                next_tick();
            end
        end
        chk("cycle.back", state_o, MAIN_GREEN);
        chk("cycle.noack", ack_cnt - acks0, 0);

        wait_state(SIDE_GREEN);
        ped_req_i = 1'b1;
        cyc();
        ped_req_i = 1'b0;
        wait_state(ALL_RED_B);
        next_tick();
        chk("ped.state", state_o, PED_WALK);
        chk("ped.ack1", ped_ack_o, 1);
        chk("ped.walk", ped_walk_o, 1);
        cyc();
        chk("ped.ack0", ped_ack_o, 0);
        next_tick();
        chk("ped.hold", state_o, PED_WALK);
        next_tick();
        chk("ped.exit", state_o, MAIN_GREEN);
        chk("ped.walk0", ped_walk_o, 0);

        wait_state(ALL_RED_B);
        while (!tick_i) cyc();
        ped_req_i = 1'b1;
        cyc();
        ped_req_i = 1'b0;
        chk("coin.state", state_o, PED_WALK);
        chk("coin.ack", ped_ack_o, 1);
        cyc();
        ped_req_i = 1'b1;
        cyc();
        ped_req_i = 1'b0;
        wait_state(MAIN_GREEN);
        wait_state(ALL_RED_B);
        next_tick();
        chk("mid.walk", state_o, PED_WALK);
        wait_state(MAIN_GREEN);
        wait_state(ALL_RED_B);
        next_tick();
        chk("mid.norepeat", state_o, MAIN_GREEN);

        wait_state(MAIN_YELLOW);
        enable_i = 1'b0;
        for (int i = 0; i < 5; i++) next_tick();
        chk("frz.state", state_o, MAIN_YELLOW);
        chk("frz.main", main_light_o, 3'b010);
        enable_i = 1'b1;
        next_tick();
        chk("frz.rem", state_o, MAIN_YELLOW);
        next_tick();
        chk("frz.exit", state_o, ALL_RED_A);

        wait_state(SIDE_YELLOW);
        ped_req_i = 1'b1;
        cyc();
        ped_req_i = 1'b0;
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        chk("mrst.state", state_o, ALL_RED_B);
        chk("mrst.main", main_light_o, 3'b100);
        chk("mrst.side", side_light_o, 3'b100);
        next_tick();
        chk("mrst.green", state_o, MAIN_GREEN);
        wait_state(ALL_RED_B);
        next_tick();
        chk("mrst.nowalk", state_o, MAIN_GREEN);

        rand_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            ped_req_i = ($urandom_range(0, 15) == 0);
            enable_i  = ($urandom_range(0, 9) != 0);
            rst_i     = ($urandom_range(0, 599) == 0);
            cyc();
        end
        rst_i = 1'b0;
        ped_req_i = 1'b0;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
